memory_responder: RTL and testbench

Memory-side responder for the CPU's memory interface: 256×8 RAM answering the CPU's address bus, read/write strobes and shared tri-state data bus, with one memory access per CPU phase rotation. It also owns system bring-up. After reset it optionally clears the RAM, then accepts a program image over a byte-stream valid/ready port, holding the CPU in reset until loading completes. It sits beside the CPU at top level, sharing `bus`.

---
 rtl/memory_responder.sv | 115 +++++++++++
 tb/tb_memory_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: 256x8 RAM on the CPU bus, plus clear/load bring-up.
// Define MEM_CLEAR_EN to zero the RAM after every reset before loading.
module memory_responder #(
    parameter int LOAD_MAX = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_clk,
    input  logic [7:0] addr_bus,
    input  logic       c_ri,
    input  logic       c_ro,
    inout  wire  [7:0] bus,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_reset,
    output logic       err_conflict
);

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    localparam logic [7:0] LAST_PTR = 8'(LOAD_MAX - 1);

`ifdef MEM_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = LOAD;
`endif

    state_t     state;
    state_t     state_nx;
    logic [7:0] ptr;
    logic [7:0] ptr_nx;
    logic [7:0] mem [256];
    logic [7:0] rdata;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       accept;
    logic       mem_op;
    logic       conflict;
    logic       bus_oe;

    assign accept   = load_valid & load_ready;
    assign mem_op   = (state == RUN) & mem_clk;
    assign conflict = mem_op & c_ri & c_ro;
    assign bus_oe   = (state == RUN) & c_ro & ~c_ri;
    assign bus      = bus_oe ? rdata : 8'bz;

    // One shared write port: clear, image load or CPU store.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        we       = 1'b0;
        waddr    = ptr;
        wdata    = 8'h00;
        unique case (state)
`ifdef MEM_CLEAR_EN
            CLEAR: begin
                we     = 1'b1;
                ptr_nx = ptr + 8'd1;
                if (ptr == 8'hFF)
                    state_nx = LOAD;
            end
`endif
            LOAD: begin
                if (accept) begin
                    we     = 1'b1;
                    wdata  = load_data;
                    ptr_nx = ptr + 8'd1;
                    if (load_last || ptr == LAST_PTR)
                        state_nx = RUN;
                end
            end
            RUN: begin
                we    = mem_op & c_ri & ~c_ro;
                waddr = addr_bus;
                wdata = bus;
            end
            default: state_nx = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RESET_STATE;
            ptr          <= 8'h00;
            load_ready   <= 1'b0;
            cpu_reset    <= 1'b1;
            err_conflict <= 1'b0;
            rdata        <= 8'h00;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            load_ready <= (state_nx == LOAD);
            cpu_reset  <= (state_nx != RUN);
            if (conflict)
                err_conflict <= 1'b1;
            if (mem_op)
                rdata <= mem[addr_bus];
        end
    end

    // RAM has no reset; contents survive a reset unless cleared.
    always_ff @(posedge clk) begin
        if (reset && we)
            mem[waddr] <= wdata;
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized bench for memory_responder with a
// transaction-level reference model and directed bring-up scenarios.
module tb_memory_responder;

    localparam int LOAD_MAX = 256;
    localparam int M_CLEAR  = 0;
    localparam int M_LOAD   = 1;
    localparam int M_RUN    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mem_clk = 1'b0;
    logic [7:0] addr_bus = 8'h00;
    logic       c_ri = 1'b0;
    logic       c_ro = 1'b0;
    wire  [7:0] bus;
    logic [7:0] tb_val = 8'h00;
    logic       tb_en = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       cpu_reset;
    logic       err_conflict;

    int n_checks = 0;
    int n_errs   = 0;

    assign bus = tb_en ? tb_val : 8'bz;

    always #5 clk = ~clk;

    memory_responder #(.LOAD_MAX(LOAD_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_clk     (mem_clk),
        .addr_bus    (addr_bus),
        .c_ri        (c_ri),
        .c_ro        (c_ro),
        .bus         (bus),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_reset   (cpu_reset),
        .err_conflict(err_conflict)
    );

    function automatic void chk(input string nm, input logic [7:0] act,
                                input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Reference model: mode, counters and a RAM image with known flags.
    int         m_mode = M_LOAD;
    bit         m_settled = 1'b0;
    int         m_cleared = 0;
    int         m_loaded = 0;
    logic [7:0] mref [256];
    bit         known [256];
    logic [7:0] m_rd = 8'h00;
    bit         m_rd_known = 1'b1;
    bit         m_err = 1'b0;
    bit         started = 1'b0;

    // At each falling edge: check outputs, then apply the coming edge.
    initial begin
        logic exp_oe;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cpu_reset", cpu_reset, 8'(m_mode != M_RUN));
                chk("load_ready", load_ready, 8'(m_mode == M_LOAD && m_settled));
                chk("err_conflict", err_conflict, 8'(m_err));
                exp_oe = (m_mode == M_RUN) && c_ro && !c_ri;
                chk("bus_oe", dut.bus_oe, 8'(exp_oe));
                if (exp_oe && m_rd_known)
                    chk("bus_data", bus, m_rd);
            end
            if (!reset) begin
`ifdef MEM_CLEAR_EN
                m_mode = M_CLEAR;
`else
                m_mode = M_LOAD;
`endif
                m_settled  = 1'b0;
                m_cleared  = 0;
                m_loaded   = 0;
                m_err      = 1'b0;
                m_rd       = 8'h00;
                m_rd_known = 1'b1;
                started    = 1'b1;
            end else begin
                case (m_mode)
                    M_CLEAR: begin
                        mref[m_cleared]  = 8'h00;
                        known[m_cleared] = 1'b1;
                        m_cleared++;
                        if (m_cleared == 256)
                            m_mode = M_LOAD;
                    end
                    M_LOAD: begin
                        if (m_settled && load_valid) begin
                            mref[m_loaded]  = load_data;
                            known[m_loaded] = 1'b1;
                            m_loaded++;
                            if (load_last || m_loaded == LOAD_MAX)
                                m_mode = M_RUN;
                        end
                    end
                    default: begin
                        if (mem_clk) begin
                            m_rd       = mref[addr_bus];
                            m_rd_known = known[addr_bus];
                            if (c_ri && c_ro)
                                m_err = 1'b1;
                            else if (c_ri) begin
                                mref[addr_bus]  = tb_val;
                                known[addr_bus] = 1'b1;
                            end
                        end
                    end
                endcase
                m_settled = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One CPU rotation: memory phase first, then two idle phases.
    task automatic rot(input logic [7:0] a, input logic ri, input logic ro,
                       input logic [7:0] d);
        addr_bus = a;
        c_ri     = ri;
        c_ro     = ro;
        tb_en    = ri;
        tb_val   = d;
        mem_clk  = 1'b1;
        step();
        mem_clk = 1'b0;
        tb_val  = 8'($urandom);
        step();
        tb_val = 8'($urandom);
        step();
    endtask

    task automatic idle_strobes();
        c_ri    = 1'b0;
        c_ro    = 1'b0;
        tb_en   = 1'b0;
        mem_clk = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (load_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("ready_wait", load_ready, 8'h01);
    endtask

    // Random image with optional gaps and noise on the CPU strobes.
    task automatic load_rand(input int n, input bit use_last);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 3000) begin
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            load_last  = use_last && (i == n - 1);
            c_ri       = 1'($urandom);
            c_ro       = 1'($urandom);
            tb_en      = c_ri;
            tb_val     = 8'($urandom);
            addr_bus   = 8'($urandom);
            mem_clk    = 1'($urandom);
            if (load_valid && load_ready)
                i++;
            step();
            guard++;
        end
        chk("load_guard", 8'(guard < 3000), 8'h01);
        load_valid = 1'b0;
        load_last  = 1'b0;
        idle_strobes();
    endtask

    task automatic traffic(input int n, input int conf_pct);
        for (int k = 0; k < n; k++) begin
            int         op;
            logic [7:0] a;
            op = $urandom_range(0, 99);
            a  = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                a = 8'($urandom);
            if (op < conf_pct)
                rot(a, 1'b1, 1'b1, 8'($urandom));
            else if (op < 40)
                rot(a, 1'b1, 1'b0, 8'($urandom));
            else if (op < 85)
                rot(a, 1'b0, 1'b1, 8'h00);
            else
                rot(a, 1'b0, 1'b0, 8'h00);
        end
        idle_strobes();
    endtask

    task automatic after_reset_release();
`ifdef MEM_CLEAR_EN
        repeat (255) step();
        chk("clear_busy", load_ready, 8'h00);
        chk("clear_cpu_rst", cpu_reset, 8'h01);
        step();
        chk("clear_done", load_ready, 8'h01);
`else
        step();
        chk("ready_first", load_ready, 8'h01);
`endif
    endtask

    initial begin
        logic [7:0] img [3];
        img = '{8'h1E, 8'h2F, 8'hFF};

        // Reset and bring-up
        reset = 1'b0;
        step();
        step();
        chk("rst_cpu_reset", cpu_reset, 8'h01);
        chk("rst_load_ready", load_ready, 8'h00);
        chk("rst_err", err_conflict, 8'h00);
        chk("rst_bus_oe", dut.bus_oe, 8'h00);
        reset = 1'b1;
        after_reset_release();
`ifdef MEM_CLEAR_EN
        for (int a = 0; a < 256; a++)
            chk("clear_mem", dut.mem[a], 8'h00);
`endif

        // Short image ended by load_last
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = (i == 2);
            if (i == 2)
                chk("cpu_rst_last", cpu_reset, 8'h01);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("cpu_rst_release", cpu_reset, 8'h00);
        chk("ready_drop", load_ready, 8'h00);
        chk("mem0", dut.mem[0], 8'h1E);
        chk("mem1", dut.mem[1], 8'h2F);
        chk("mem2", dut.mem[2], 8'hFF);

        // Directed read, hi-Z and write/readback
        rot(8'h2F, 1'b1, 1'b0, 8'hA5);
        rot(8'h2F, 1'b0, 1'b1, 8'h00);
        chk("read_a5", bus, 8'hA5);
        c_ro = 1'b0;
        #1;
        chk("hiz_after_read", dut.bus_oe, 8'h00);
        rot(8'h80, 1'b1, 1'b0, 8'h3C);
        rot(8'h80, 1'b0, 1'b1, 8'h00);
        chk("readback_3c", bus, 8'h3C);
        idle_strobes();

        traffic(300, 0);

        // Conflict
        rot(8'h10, 1'b1, 1'b0, 8'h00);
        rot(8'h10, 1'b1, 1'b1, 8'h77);
        chk("conf_err", err_conflict, 8'h01);
        chk("conf_no_drive", dut.bus_oe, 8'h00);
        chk("conf_mem", dut.mem[8'h10], 8'h00);
        rot(8'h10, 1'b0, 1'b1, 8'h00);
        chk("conf_read", bus, 8'h00);
        chk("conf_sticky", err_conflict, 8'h01);
        traffic(20, 0);
        chk("conf_sticky2", err_conflict, 8'h01);

        // Reset mid-LOAD
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("err_cleared", err_conflict, 8'h00);
        after_reset_release();
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom_range(1, 255));
            step();
        end
        load_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_cpu_reset", cpu_reset, 8'h01);
        chk("mid_load_ready", load_ready, 8'h00);
        after_reset_release();
`ifdef MEM_CLEAR_EN
        for (int a = 0; a < 5; a++)
            chk("mid_clear_mem", dut.mem[a], 8'h00);
`endif

        // Full-size image ends on LOAD_MAX, then noisy traffic
        load_rand(LOAD_MAX, 1'b0);
        step();
        chk("max_cpu_release", cpu_reset, 8'h00);
        traffic(200, 5);

        // Random short image after another reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        after_reset_release();
        load_rand($urandom_range(1, 40), 1'b1);
        step();
        chk("short_cpu_release", cpu_reset, 8'h00);
        traffic(150, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
